// File: rtl/rsv_station_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsv_station_pkg
// Description : Shared widths, opcode encodings, entry/issue record types and
//               the broadcast wake-up helper for the reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
package rsv_station_pkg;

   localparam int INS_OP_W  = 6;
   localparam int REG_DAT_W = 32;
   localparam int ROB_ADD_W = 5;
   localparam int RS_SIZE   = 16;
   localparam int RS_ADD_W  = 4;
   localparam int AGE_W     = 8;

   localparam logic [INS_OP_W-1:0] OP_NOP = 6'd0;
   localparam logic [INS_OP_W-1:0] OP_ADD = 6'd1;
   localparam logic [INS_OP_W-1:0] OP_SUB = 6'd2;
   localparam logic [INS_OP_W-1:0] OP_AND = 6'd3;
   localparam logic [INS_OP_W-1:0] OP_OR  = 6'd4;
   localparam logic [INS_OP_W-1:0] OP_XOR = 6'd5;
   localparam logic [INS_OP_W-1:0] OP_LW  = 6'd6;
   localparam logic [INS_OP_W-1:0] OP_SW  = 6'd7;
   localparam logic [INS_OP_W-1:0] OP_BEQ = 6'd8;

   // One station slot (busy bit and age are kept separately)
   typedef struct packed {
      logic [INS_OP_W-1:0]  op;
      logic [REG_DAT_W-1:0] pc;
      logic [REG_DAT_W-1:0] imm;
      logic                 rdy1;
      logic [ROB_ADD_W-1:0] q1;
      logic [REG_DAT_W-1:0] v1;
      logic                 rdy2;
      logic [ROB_ADD_W-1:0] q2;
      logic [REG_DAT_W-1:0] v2;
      logic [ROB_ADD_W-1:0] qd;
   } rs_entry_t;

   // Bundle handed to the execution unit
   typedef struct packed {
      logic [INS_OP_W-1:0]  op;
      logic [REG_DAT_W-1:0] pc;
      logic [REG_DAT_W-1:0] imm;
      logic [REG_DAT_W-1:0] vs1;
      logic [REG_DAT_W-1:0] vs2;
      logic [ROB_ADD_W-1:0] qd;
   } issue_t;

   // Snoop both result buses; each waiting operand grabs a value whose tag matches
   function automatic rs_entry_t rs_wake(
      input rs_entry_t            e,
      input logic                 ex_en,
      input logic [ROB_ADD_W-1:0] ex_qd,
      input logic [REG_DAT_W-1:0] ex_vd,
      input logic                 lsb_en,
      input logic [ROB_ADD_W-1:0] lsb_qd,
      input logic [REG_DAT_W-1:0] lsb_vd
   );
      rs_entry_t r;
      r = e;
      if (!e.rdy1 && ex_en && (e.q1 == ex_qd)) begin
         r.rdy1 = 1'b1;
         r.v1   = ex_vd;
      end
      if (!e.rdy1 && lsb_en && (e.q1 == lsb_qd)) begin
         r.rdy1 = 1'b1;
         r.v1   = lsb_vd;
      end
      if (!e.rdy2 && ex_en && (e.q2 == ex_qd)) begin
         r.rdy2 = 1'b1;
         r.v2   = ex_vd;
      end
      if (!e.rdy2 && lsb_en && (e.q2 == lsb_qd)) begin
         r.rdy2 = 1'b1;
         r.v2   = lsb_vd;
      end
      return r;
   endfunction

   // Saturating age increment
   function automatic logic [AGE_W-1:0] rs_sat_inc(input logic [AGE_W-1:0] a);
      return (&a) ? a : a + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rsv_station_if.sv
`default_nettype none
// ============================================================================
// Module      : rsv_station_if
// Description : Dispatch, result-broadcast and issue buses of the reservation
//               station. master = front end / producers, slave = station.
// Revision    : 1.0 - initial release
// ============================================================================
interface rsv_station_if;
   import rsv_station_pkg::*;

   logic                 iDP_En;
   logic [INS_OP_W-1:0]  iDP_Op;
   logic [REG_DAT_W-1:0] iDP_Pc;
   logic [REG_DAT_W-1:0] iDP_Imm;
   logic                 iDP_Rdy1;
   logic                 iDP_Rdy2;
   logic [ROB_ADD_W-1:0] iDP_Qs1;
   logic [ROB_ADD_W-1:0] iDP_Qs2;
   logic [REG_DAT_W-1:0] iDP_Vs1;
   logic [REG_DAT_W-1:0] iDP_Vs2;
   logic [ROB_ADD_W-1:0] iDP_Qd;
   logic                 oDP_Full;

   logic                 iEX_En;
   logic [ROB_ADD_W-1:0] iEX_Qd;
   logic [REG_DAT_W-1:0] iEX_Vd;
   logic                 iLSB_En;
   logic [ROB_ADD_W-1:0] iLSB_Qd;
   logic [REG_DAT_W-1:0] iLSB_Vd;

   logic                 oEX_En;
   logic [INS_OP_W-1:0]  oEX_Op;
   logic [REG_DAT_W-1:0] oEX_Pc;
   logic [REG_DAT_W-1:0] oEX_Imm;
   logic [REG_DAT_W-1:0] oEX_Vs1;
   logic [REG_DAT_W-1:0] oEX_Vs2;
   logic [ROB_ADD_W-1:0] oEX_Qd;

   modport master (
      output iDP_En, iDP_Op, iDP_Pc, iDP_Imm, iDP_Rdy1, iDP_Rdy2,
             iDP_Qs1, iDP_Qs2, iDP_Vs1, iDP_Vs2, iDP_Qd,
             iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
      input  oDP_Full, oEX_En, oEX_Op, oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2, oEX_Qd
   );

   modport slave (
      input  iDP_En, iDP_Op, iDP_Pc, iDP_Imm, iDP_Rdy1, iDP_Rdy2,
             iDP_Qs1, iDP_Qs2, iDP_Vs1, iDP_Vs2, iDP_Qd,
             iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
      output oDP_Full, oEX_En, oEX_Op, oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2, oEX_Qd
   );

endinterface
`default_nettype wire

// File: rtl/rsv_station_select.sv
`default_nettype none
// ============================================================================
// Module      : rs_select
// Description : Combinational lowest-index priority encoder: returns the index
//               of the lowest set bit and whether any bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_select #(
   parameter int N = 16,
   parameter int W = 4
)(
   input  wire [N-1:0] i_vec,
   output logic [W-1:0] o_idx,
   output logic         o_found
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_found = 1'b1;
            o_idx   = W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rsv_station.sv
`default_nettype none
// ============================================================================
// Module      : rsv_station
// Description : Out-of-order reservation station. Holds dispatched
//               instructions, wakes waiting operands from the ALU and LSB
//               result buses, and issues one ready entry per cycle.
//               Build option RS_ISSUE_OLDEST_EN: issue the oldest ready entry
//               (saturating per-entry age, lowest index breaks ties) instead
//               of the lowest-index ready entry.
// Revision    : 1.0 - initial release
// ============================================================================
module rsv_station
   import rsv_station_pkg::*;
#(
   parameter int RS_SIZE  = rsv_station_pkg::RS_SIZE,
   parameter int RS_ADD_W = rsv_station_pkg::RS_ADD_W
)(
   input wire           clk,
   input wire           rst,
   input wire           en,
   input wire           iClr,
   rsv_station_if.slave bus
);

   logic [RS_SIZE-1:0]  busy_q, busy_d;
   rs_entry_t           ent_q [RS_SIZE];
   rs_entry_t           ent_d [RS_SIZE];
   logic                ex_en_q, ex_en_d;
   issue_t              ex_q, ex_d;

   logic [RS_SIZE-1:0]  free_vec;
   logic [RS_SIZE-1:0]  ready_vec;
   logic [RS_SIZE-1:0]  cand_vec;
   logic [RS_ADD_W-1:0] free_idx, iss_idx;
   logic                free_found, iss_found;
   logic                full;
   logic                dp_fire;
   rs_entry_t           dp_ent;

   assign free_vec = ~busy_q;
   assign full     = &busy_q;
   // Free slots come from registered busy bits, so a slot freed by issue is
   // only visible to dispatch on the following cycle.
   assign dp_fire  = bus.iDP_En && !full;

   rs_select #(.N(RS_SIZE), .W(RS_ADD_W)) u_free_sel (
      .i_vec   (free_vec),
      .o_idx   (free_idx),
      .o_found (free_found)
   );

   // Ready entries are judged from registered operand state only
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         ready_vec[i] = busy_q[i] && ent_q[i].rdy1 && ent_q[i].rdy2;
      end
   end

`ifdef RS_ISSUE_OLDEST_EN
   logic [AGE_W-1:0] age_q [RS_SIZE];
   logic [AGE_W-1:0] age_d [RS_SIZE];
   logic [AGE_W-1:0] max_age;

   // Largest age among ready entries; every ready entry at that age is a candidate
   always_comb begin
      max_age = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (ready_vec[i] && (age_q[i] > max_age)) begin
            max_age = age_q[i];
         end
         cand_vec[i] = 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
         cand_vec[i] = ready_vec[i] && (age_q[i] == max_age);
      end
   end

   // Ages grow every active edge; the dispatched slot restarts at zero
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         age_d[i] = age_q[i];
      end
      if (en) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            age_d[i] = rs_sat_inc(age_q[i]);
         end
         if (!iClr && dp_fire) begin
            age_d[free_idx] = '0;
         end
      end
   end

   // Age register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            age_q[i] <= '0;
         end
      end else begin
         age_q <= age_d;
      end
   end
`else
   // Lowest index wins among all ready entries
   always_comb begin
      cand_vec = ready_vec;
   end
`endif

   rs_select #(.N(RS_SIZE), .W(RS_ADD_W)) u_iss_sel (
      .i_vec   (cand_vec),
      .o_idx   (iss_idx),
      .o_found (iss_found)
   );

   // Incoming dispatch record, already snooping this cycle's broadcasts
   always_comb begin
      dp_ent      = '0;
      dp_ent.op   = bus.iDP_Op;
      dp_ent.pc   = bus.iDP_Pc;
      dp_ent.imm  = bus.iDP_Imm;
      dp_ent.rdy1 = bus.iDP_Rdy1;
      dp_ent.q1   = bus.iDP_Qs1;
      dp_ent.v1   = bus.iDP_Rdy1 ? bus.iDP_Vs1 : '0;
      dp_ent.rdy2 = bus.iDP_Rdy2;
      dp_ent.q2   = bus.iDP_Qs2;
      dp_ent.v2   = bus.iDP_Rdy2 ? bus.iDP_Vs2 : '0;
      dp_ent.qd   = bus.iDP_Qd;
      dp_ent = rs_wake(dp_ent, bus.iEX_En, bus.iEX_Qd, bus.iEX_Vd,
                       bus.iLSB_En, bus.iLSB_Qd, bus.iLSB_Vd);
   end

   // Next state: freeze when en low, flush on iClr, else capture/issue/dispatch
   always_comb begin
      busy_d  = busy_q;
      ent_d   = ent_q;
      ex_en_d = ex_en_q;
      ex_d    = ex_q;
      if (en) begin
         if (iClr) begin
            busy_d  = '0;
            ex_en_d = 1'b0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy_q[i]) begin
                  ent_d[i] = rs_wake(ent_q[i], bus.iEX_En, bus.iEX_Qd, bus.iEX_Vd,
                                     bus.iLSB_En, bus.iLSB_Qd, bus.iLSB_Vd);
               end
            end
            ex_en_d = 1'b0;
            if (iss_found) begin
               busy_d[iss_idx] = 1'b0;
               ex_en_d         = 1'b1;
               ex_d.op         = ent_q[iss_idx].op;
               ex_d.pc         = ent_q[iss_idx].pc;
               ex_d.imm        = ent_q[iss_idx].imm;
               ex_d.vs1        = ent_q[iss_idx].v1;
               ex_d.vs2        = ent_q[iss_idx].v2;
               ex_d.qd         = ent_q[iss_idx].qd;
            end
            // The issuing slot is busy, so it can never be the free slot
            if (dp_fire && free_found) begin
               busy_d[free_idx] = 1'b1;
               ent_d[free_idx]  = dp_ent;
            end
         end
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         ex_en_q <= 1'b0;
         ex_q    <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         busy_q  <= busy_d;
         ex_en_q <= ex_en_d;
         ex_q    <= ex_d;
         ent_q   <= ent_d;
      end
   end

   assign bus.oDP_Full = full;
   assign bus.oEX_En   = ex_en_q;
   assign bus.oEX_Op   = ex_q.op;
   assign bus.oEX_Pc   = ex_q.pc;
   assign bus.oEX_Imm  = ex_q.imm;
   assign bus.oEX_Vs1  = ex_q.vs1;
   assign bus.oEX_Vs2  = ex_q.vs2;
   assign bus.oEX_Qd   = ex_q.qd;

endmodule
`default_nettype wire

// File: tb/tb_rsv_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsv_station
// Description : Self-checking bench for rsv_station. Expected issue bundles
//               are queued as instructions are dispatched and popped when the
//               station issues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsv_station;
   import rsv_station_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic iClr;

   int n_run  = 0;
   int n_fail = 0;
   issue_t exp_q[$];

   always #5 clk = ~clk;

   rsv_station_if bus();

   rsv_station dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .iClr (iClr),
      .bus  (bus)
   );

   function automatic issue_t got();
      issue_t g;
      g.op  = bus.oEX_Op;
      g.pc  = bus.oEX_Pc;
      g.imm = bus.oEX_Imm;
      g.vs1 = bus.oEX_Vs1;
      g.vs2 = bus.oEX_Vs2;
      g.qd  = bus.oEX_Qd;
      return g;
   endfunction

   function automatic issue_t mk(input logic [INS_OP_W-1:0] op, input logic [REG_DAT_W-1:0] v1,
                                 input logic [REG_DAT_W-1:0] v2, input logic [ROB_ADD_W-1:0] qd);
      issue_t e;
      e.op  = op;
      e.pc  = (REG_DAT_W'(qd) << 2) + 32'h1000;
      e.imm = REG_DAT_W'(qd) + 32'd100;
      e.vs1 = v1;
      e.vs2 = v2;
      e.qd  = qd;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.iDP_En  = 1'b0;
      bus.iEX_En  = 1'b0;
      bus.iLSB_En = 1'b0;
   endtask

   task automatic dp(input logic [INS_OP_W-1:0] op,
                     input logic r1, input logic [ROB_ADD_W-1:0] q1, input logic [REG_DAT_W-1:0] v1,
                     input logic r2, input logic [ROB_ADD_W-1:0] q2, input logic [REG_DAT_W-1:0] v2,
                     input logic [ROB_ADD_W-1:0] qd);
      bus.iDP_En   = 1'b1;
      bus.iDP_Op   = op;
      bus.iDP_Pc   = (REG_DAT_W'(qd) << 2) + 32'h1000;
      bus.iDP_Imm  = REG_DAT_W'(qd) + 32'd100;
      bus.iDP_Rdy1 = r1;
      bus.iDP_Qs1  = q1;
      bus.iDP_Vs1  = v1;
      bus.iDP_Rdy2 = r2;
      bus.iDP_Qs2  = q2;
      bus.iDP_Vs2  = v2;
      bus.iDP_Qd   = qd;
   endtask

   task automatic ex_bcast(input logic [ROB_ADD_W-1:0] qd, input logic [REG_DAT_W-1:0] vd);
      bus.iEX_En = 1'b1;
      bus.iEX_Qd = qd;
      bus.iEX_Vd = vd;
   endtask

   task automatic lsb_bcast(input logic [ROB_ADD_W-1:0] qd, input logic [REG_DAT_W-1:0] vd);
      bus.iLSB_En = 1'b1;
      bus.iLSB_Qd = qd;
      bus.iLSB_Vd = vd;
   endtask

   task automatic flush();
      idle();
      iClr = 1'b1;
      step();
      iClr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en = 1'b1;
      iClr = 1'b0;
      idle();
      dp(OP_ADD, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2, 5'd9);
      step();
      step();
      n_run++;
      if (bus.oEX_En !== 1'b0) begin n_fail++; $display("FAIL reset_en got=%b exp=0", bus.oEX_En); end
      n_run++;
      if (bus.oDP_Full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", bus.oDP_Full); end
      n_run++;
      if (got() !== issue_t'(0)) begin n_fail++; $display("FAIL reset_data got=%h exp=0", got()); end
      idle();
      rst = 1'b0;
      step();
      step();
      n_run++;
      if (bus.oEX_En !== 1'b0) begin n_fail++; $display("FAIL reset_nodispatch got=%b exp=0", bus.oEX_En); end
   endtask

   task automatic test_reset_mid();
      dp(OP_XOR, 1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h88, 5'd11);
      step();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_run++;
      if (bus.oEX_En !== 1'b0 || got() !== issue_t'(0)) begin
         n_fail++; $display("FAIL reset_mid got_en=%b got=%h exp_en=0 exp=0", bus.oEX_En, got());
      end
      step();
      step();
      n_run++;
      if (bus.oEX_En !== 1'b0) begin n_fail++; $display("FAIL reset_mid_drop got=%b exp=0", bus.oEX_En); end
   endtask

   task automatic test_basic();
      issue_t e;
      dp(OP_ADD, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7, 5'd3);
      exp_q.push_back(mk(OP_ADD, 32'd5, 32'd7, 5'd3));
      step();
      idle();
      n_run++;
      if (bus.oEX_En !== 1'b0) begin n_fail++; $display("FAIL basic_early got=%b exp=0", bus.oEX_En); end
      step();
      n_run++;
      if (bus.oEX_En !== 1'b1) begin n_fail++; $display("FAIL basic_en got=%b exp=1", bus.oEX_En); end
      e = exp_q.pop_front();
      n_run++;
      if (got() !== e) begin n_fail++; $display("FAIL basic_data got=%h exp=%h", got(), e); end
      step();
      n_run++;
      if (bus.oEX_En !== 1'b0) begin n_fail++; $display("FAIL basic_drop got=%b exp=0", bus.oEX_En); end
   endtask

   task automatic test_ex_wakeup();
      issue_t e;
      dp(OP_SUB, 1'b0, 5'd6, 32'hDEAD, 1'b1, 5'd0, 32'd2, 5'd4);
      exp_q.push_back(mk(OP_SUB, 32'h10, 32'd2, 5'd4));
      step();
      idle();
      step();
      n_run++;
      if (bus.oEX_En !== 1'b0) begin n_fail++; $display("FAIL exwake_wait got=%b exp=0", bus.oEX_En); end
      ex_bcast(5'd6, 32'h10);
      step();
      idle();
      n_run++;
      if (bus.oEX_En !== 1'b0) begin n_fail++; $display("FAIL exwake_latency got=%b exp=0", bus.oEX_En); end
      step();
      n_run++;
      if (bus.oEX_En !== 1'b1) begin n_fail++; $display("FAIL exwake_en got=%b exp=1", bus.oEX_En); end
      e = exp_q.pop_front();
      n_run++;
      if (got() !== e) begin n_fail++; $display("FAIL exwake_data got=%h exp=%h", got(), e); end
      step();
   endtask

   task automatic test_same_cycle_capture();
      issue_t e;
      dp(OP_LW, 1'b1, 5'd0, 32'd1, 1'b0, 5'd9, 32'hBAD, 5'd8);
      lsb_bcast(5'd9, 32'hAB);
      exp_q.push_back(mk(OP_LW, 32'd1, 32'hAB, 5'd8));
      step();
      idle();
      step();
      n_run++;
      if (bus.oEX_En !== 1'b1) begin n_fail++; $display("FAIL samecyc_en got=%b exp=1", bus.oEX_En); end
      e = exp_q.pop_front();
      n_run++;
      if (got() !== e) begin n_fail++; $display("FAIL samecyc_data got=%h exp=%h", got(), e); end
      step();
   endtask

   task automatic test_full();
      issue_t e;
      for (int i = 0; i < 16; i++) begin
         dp(OP_ADD, 1'b0, 5'(10 + i), 32'd0, 1'b1, 5'd0, 32'(i), 5'(i));
         step();
         if (i == 14) begin
            n_run++;
            if (bus.oDP_Full !== 1'b0) begin n_fail++; $display("FAIL full_15 got=%b exp=0", bus.oDP_Full); end
         end
      end
      idle();
      n_run++;
      if (bus.oDP_Full !== 1'b1) begin n_fail++; $display("FAIL full_16 got=%b exp=1", bus.oDP_Full); end
      dp(OP_XOR, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2, 5'd31);
      step();
      idle();
      step();
      n_run++;
      if (bus.oEX_En !== 1'b0 || bus.oDP_Full !== 1'b1) begin
         n_fail++; $display("FAIL full_drop got_en=%b got_full=%b exp_en=0 exp_full=1", bus.oEX_En, bus.oDP_Full);
      end
      ex_bcast(5'd15, 32'h55);
      exp_q.push_back(mk(OP_ADD, 32'h55, 32'd5, 5'd5));
      step();
      idle();
      step();
      n_run++;
      if (bus.oEX_En !== 1'b1) begin n_fail++; $display("FAIL full_wake_en got=%b exp=1", bus.oEX_En); end
      e = exp_q.pop_front();
      n_run++;
      if (got() !== e) begin n_fail++; $display("FAIL full_wake_data got=%h exp=%h", got(), e); end
      n_run++;
      if (bus.oDP_Full !== 1'b0) begin n_fail++; $display("FAIL full_free got=%b exp=0", bus.oDP_Full); end
      step();
      n_run++;
      if (bus.oEX_En !== 1'b0) begin n_fail++; $display("FAIL full_after got=%b exp=0", bus.oEX_En); end
      flush();
   endtask

   task automatic test_flush();
      int issues;
      for (int i = 0; i < 4; i++) begin
         dp(OP_OR, 1'b0, 5'(20 + i), 32'd0, 1'b1, 5'd0, 32'd1, 5'(i + 1));
         step();
      end
      idle();
      iClr = 1'b1;
      ex_bcast(5'd20, 32'd1);
      dp(OP_ADD, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1, 5'd30);
      step();
      iClr = 1'b0;
      idle();
      n_run++;
      if (bus.oEX_En !== 1'b0 || bus.oDP_Full !== 1'b0) begin
         n_fail++; $display("FAIL flush_now got_en=%b got_full=%b exp=0", bus.oEX_En, bus.oDP_Full);
      end
      issues = 0;
      for (int k = 0; k < 6; k++) begin
         if (k < 3) ex_bcast(5'(21 + k), 32'd2);
         else idle();
         step();
         if (bus.oEX_En === 1'b1) issues++;
      end
      idle();
      n_run++;
      if (issues !== 0) begin n_fail++; $display("FAIL flush_noissue got=%0d exp=0", issues); end
      for (int i = 0; i < 16; i++) begin
         dp(OP_ADD, 1'b0, 5'd29, 32'd0, 1'b0, 5'd29, 32'd0, 5'(i));
         step();
         if (i == 14) begin
            n_run++;
            if (bus.oDP_Full !== 1'b0) begin n_fail++; $display("FAIL flush_free15 got=%b exp=0", bus.oDP_Full); end
         end
      end
      idle();
      n_run++;
      if (bus.oDP_Full !== 1'b1) begin n_fail++; $display("FAIL flush_free16 got=%b exp=1", bus.oDP_Full); end
      flush();
   endtask

   task automatic test_en_low();
      issue_t e;
      bit seen;
      en = 1'b0;
      dp(OP_AND, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 32'd4, 5'd7);
      step();
      idle();
      en = 1'b1;
      step();
      step();
      n_run++;
      if (bus.oEX_En !== 1'b0) begin n_fail++; $display("FAIL enlow_drop got=%b exp=0", bus.oEX_En); end
      dp(OP_AND, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 32'd4, 5'd7);
      exp_q.push_back(mk(OP_AND, 32'd3, 32'd4, 5'd7));
      step();
      idle();
      en = 1'b0;
      step();
      step();
      step();
      n_run++;
      if (bus.oEX_En !== 1'b0) begin n_fail++; $display("FAIL enlow_freeze got=%b exp=0", bus.oEX_En); end
      en = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (bus.oEX_En === 1'b1) begin seen = 1'b1; break; end
      end
      e = exp_q.pop_front();
      n_run++;
      if (!seen || got() !== e) begin n_fail++; $display("FAIL enlow_issue got_en=%b got=%h exp=%h", seen, got(), e); end
      en = 1'b0;
      step();
      step();
      n_run++;
      if (bus.oEX_En !== 1'b1) begin n_fail++; $display("FAIL enlow_hold got=%b exp=1", bus.oEX_En); end
      en = 1'b1;
      step();
      n_run++;
      if (bus.oEX_En !== 1'b0) begin n_fail++; $display("FAIL enlow_resume got=%b exp=0", bus.oEX_En); end
   endtask

   task automatic test_order();
      issue_t e, e7, e2;
      for (int i = 0; i < 8; i++) begin
         dp(OP_ADD, 1'b0, (i == 2) ? 5'd1 : ((i == 7) ? 5'd30 : 5'd29), 32'd0,
            1'b1, 5'd0, 32'(i), 5'(i));
         step();
      end
      idle();
      ex_bcast(5'd1, 32'h11);
      exp_q.push_back(mk(OP_ADD, 32'h11, 32'd2, 5'd2));
      step();
      idle();
      step();
      e = exp_q.pop_front();
      n_run++;
      if (bus.oEX_En !== 1'b1 || got() !== e) begin
         n_fail++; $display("FAIL order_pre got_en=%b got=%h exp=%h", bus.oEX_En, got(), e);
      end
      step();
      dp(OP_SUB, 1'b0, 5'd30, 32'd0, 1'b1, 5'd0, 32'h22, 5'd20);
      step();
      idle();
      step();
      e7 = mk(OP_ADD, 32'h33, 32'd7, 5'd7);
      e2 = mk(OP_SUB, 32'h33, 32'h22, 5'd20);
`ifdef RS_ISSUE_OLDEST_EN
      exp_q.push_back(e7);
      exp_q.push_back(e2);
`else
      exp_q.push_back(e2);
      exp_q.push_back(e7);
`endif
      ex_bcast(5'd30, 32'h33);
      step();
      idle();
      step();
      e = exp_q.pop_front();
      n_run++;
      if (bus.oEX_En !== 1'b1 || got() !== e) begin
         n_fail++; $display("FAIL order_first got_en=%b got=%h exp=%h", bus.oEX_En, got(), e);
      end
      step();
      e = exp_q.pop_front();
      n_run++;
      if (bus.oEX_En !== 1'b1 || got() !== e) begin
         n_fail++; $display("FAIL order_second got_en=%b got=%h exp=%h", bus.oEX_En, got(), e);
      end
      step();
      n_run++;
      if (bus.oEX_En !== 1'b0) begin n_fail++; $display("FAIL order_done got=%b exp=0", bus.oEX_En); end
      flush();
   endtask

   initial begin
      bus.iDP_Op = '0; bus.iDP_Pc = '0; bus.iDP_Imm = '0;
      bus.iDP_Rdy1 = 1'b0; bus.iDP_Rdy2 = 1'b0;
      bus.iDP_Qs1 = '0; bus.iDP_Qs2 = '0; bus.iDP_Vs1 = '0; bus.iDP_Vs2 = '0; bus.iDP_Qd = '0;
      bus.iEX_Qd = '0; bus.iEX_Vd = '0; bus.iLSB_Qd = '0; bus.iLSB_Vd = '0;
      idle();
      test_reset();
      test_reset_mid();
      test_basic();
      test_ex_wakeup();
      test_same_cycle_capture();
      test_full();
      test_flush();
      test_en_low();
      test_order();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/rsv_station.md
RSV_STATION -- requirements
Module: rsv_station

Interface
REQ-001 Parameters: RS_SIZE, default 16, number of entries; RS_ADD_W, default 4, entry index width (log2 RS_SIZE).
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 en  in  1  global ready; low freezes all state and outputs.
REQ-005 iClr  in  1  flush after misprediction.
REQ-006 iDP_En  in  1  dispatch valid.
REQ-007 iDP_Op  in  INS_OP_W  opcode; iDP_Pc, iDP_Imm  in  REG_DAT_W each.
REQ-008 iDP_Rdy1, iDP_Rdy2  in  1 each  operand already valid.
REQ-009 iDP_Qs1, iDP_Qs2  in  ROB_ADD_W each  producer tags, used when Rdy low.
REQ-010 iDP_Vs1, iDP_Vs2  in  REG_DAT_W each  operand values, used when Rdy high.
REQ-011 iDP_Qd  in  ROB_ADD_W  destination ROB tag.
REQ-012 oDP_Full  out  1  no free entry.
REQ-013 iEX_En, iEX_Qd, iEX_Vd  in  1/ROB_ADD_W/REG_DAT_W  ALU result broadcast.
REQ-014 iLSB_En, iLSB_Qd, iLSB_Vd  in  1/ROB_ADD_W/REG_DAT_W  load result broadcast.
REQ-015 oEX_En, oEX_Op, oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2, oEX_Qd  out  issue bundle to execution unit, widths as dispatch fields.

Function
REQ-016 Entry: busy, op, pc, imm, rdy1/q1/v1, rdy2/q2/v2, qd.
REQ-017 Dispatch (iDP_En, en, !iClr) SHALL write the lowest-index free entry at the posedge; iDP_En while oDP_Full is ignored, no state change.
REQ-018 oDP_Full SHALL be combinational from registered busy bits; equals all entries busy.
REQ-019 Each posedge, every busy entry with rdyN low and qN equal to an enabled broadcast tag SHALL capture that Vd and set rdyN; both buses checked independently.
REQ-020 Dispatch SHALL apply the same capture to its incoming operands against broadcasts in the same cycle, so no broadcast is missed.
REQ-021 Issue: among entries busy with rdy1 and rdy2 set (registered state), one is selected per cycle; its fields load the oEX_* registers, oEX_En set to 1 for one cycle, entry busy cleared same edge.
REQ-022 No ready entry: oEX_En goes to 0; other oEX_* hold prior value.
REQ-023 Minimum latency: dispatch with both operands ready at edge t -> oEX_En high after edge t+1; broadcast capture at edge t -> issue no earlier than edge t+1.
REQ-024 Freed entry is reusable by dispatch at the next edge, not the issuing edge.
REQ-025 iClr SHALL clear all busy bits and oEX_En at the posedge, overriding dispatch, capture and issue.
REQ-026 en low SHALL override everything except rst.

Reset
REQ-027 rst: all busy bits 0, oEX_En 0, all oEX_* data 0, oDP_Full 0; takes effect even mid-capture or mid-issue.

Configuration
REQ-028 RS_ISSUE_OLDEST_EN defined: each entry holds an age counter, zeroed on dispatch and incremented each edge, saturating; issue selects the oldest ready entry, lowest index breaking ties.
REQ-029 RS_ISSUE_OLDEST_EN undefined: issue selects the lowest-index ready entry; no age storage.

Structure
REQ-030 Shared header holds INS_OP_W, REG_DAT_W, ROB_ADD_W, RS_SIZE, RS_ADD_W, opcode encodings; none redefined locally.
REQ-031 One sub-module rs_select: combinational lowest-index priority encoder (vector -> index + found), instanced for the free slot and for ready issue.

Verification
REQ-032 Dispatch ADD, Rdy1=Rdy2=1, Vs1=5, Vs2=7, Qd=3 -> next cycle oEX_En=1, Vs1=5, Vs2=7, Qd=3; following cycle oEX_En=0.
REQ-033 Dispatch Rdy1=0 Qs1=6; two cycles later iEX_En Qd=6 Vd=0x10 -> oEX_En with Vs1=0x10 one edge after the broadcast.
REQ-034 Dispatch Qs2=9 in the same cycle as iLSB_En Qd=9 Vd=0xAB -> entry captures, issues Vs2=0xAB.
REQ-035 Fill 16 unready entries -> oDP_Full=1; 17th dispatch dropped; one broadcast wakes entry 5 -> issue, then oDP_Full=0.
REQ-036 iClr with 4 busy entries and a matching broadcast -> all free, oEX_En=0, no later issue of flushed entries.
REQ-037 RS_ISSUE_OLDEST_EN: entry 7 dispatched before entry 2, both woken by one broadcast -> entry 7 issues first; macro undefined -> entry 2 first.
